// File: rtl/morse_symbol_sequencer.sv
// Morse key timing front-end: measures mark/space lengths in unit periods,
// classifies them into dit/dah/letter-gap/word-gap events and queues them in a FWFT FIFO.
module morse_symbol_sequencer #(
   parameter int unsigned UNIT_CYCLES = 66,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       signal,
   output logic [1:0] sym,
   output logic       sym_valid,
   input  logic       sym_ready,
   output logic       overflow,
   output logic       busy
);

   localparam int unsigned       AW           = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CNT_W-1:0]  LP_UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
   localparam logic [AW:0]       LP_FULL      = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MARK,
      S_SPACE,
      S_LGAP
   } state_t;

   typedef enum logic [1:0] {
      SYM_DIT    = 2'b00,
      SYM_DAH    = 2'b01,
      SYM_LETTER = 2'b10,
      SYM_WORD   = 2'b11
   } sym_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_signal_q;
   logic [CNT_W-1:0] r_presc;
   logic [2:0]       r_units;
   logic             r_pending;
   logic             r_overflow;

   logic             w_edge;
   logic             w_unit_done;
   logic             w_space_tick;
   logic [2:0]       w_units_now;

   logic             w_push;
   sym_t             w_push_sym;
   logic             w_pending_set;
   logic             w_pending_clr;

   sym_t             r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_empty;
   logic             w_full;
   logic             w_pop;
   logic             w_wr_en;

   // ------------------------------------------------------------------
   // Level timing
   // ------------------------------------------------------------------
   assign w_edge       = (signal != r_signal_q);
   assign w_unit_done  = (r_presc == LP_UNIT_LAST);
   assign w_space_tick = !w_edge && w_unit_done;
   // Unit count including a unit that completes this very cycle, so a mark
   // of exactly N*UNIT_CYCLES clocks is classified as N units at its fall.
   assign w_units_now  = (w_unit_done && (r_units != 3'd7)) ? r_units + 3'd1 : r_units;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_signal_q <= 1'b0;
         r_presc    <= '0;
         r_units    <= '0;
      end else begin
         r_signal_q <= signal;
         if (w_edge) begin
            r_presc <= '0;
            r_units <= '0;
         end else if (w_unit_done) begin
            r_presc <= '0;
            r_units <= w_units_now;
         end else begin
            r_presc <= r_presc + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Element classifier FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pending <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pending_set) begin
            r_pending <= 1'b1;
         end else if (w_pending_clr) begin
            r_pending <= 1'b0;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_push        = 1'b0;
      w_push_sym    = SYM_DIT;
      w_pending_set = 1'b0;
      w_pending_clr = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_edge && signal) begin
               w_state_nxt = S_MARK;
            end
         end
         S_MARK: begin
            if (w_edge && !signal) begin
               if (w_units_now == 3'd0) begin
                  // Glitch: resume the gap only if a mark is awaiting its letter gap.
                  w_state_nxt = r_pending ? S_SPACE : S_IDLE;
               end else begin
                  w_push        = 1'b1;
                  w_push_sym    = (w_units_now >= 3'd3) ? SYM_DAH : SYM_DIT;
                  w_pending_set = 1'b1;
                  w_state_nxt   = S_SPACE;
               end
            end
         end
         S_SPACE: begin
            if (w_edge && signal) begin
               w_state_nxt = S_MARK;
            end else if (w_space_tick && (r_units == 3'd2)) begin
               w_push        = 1'b1;
               w_push_sym    = SYM_LETTER;
               w_pending_clr = 1'b1;
               w_state_nxt   = S_LGAP;
            end
         end
         S_LGAP: begin
            if (w_edge && signal) begin
               w_state_nxt = S_MARK;
            end else if (w_space_tick && (r_units == 3'd6)) begin
               w_push      = 1'b1;
               w_push_sym  = SYM_WORD;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Symbol FIFO (first-word-fall-through)
   // ------------------------------------------------------------------
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == LP_FULL);
   assign w_pop   = !w_empty && sym_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign w_wr_en = w_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= w_push_sym;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_wr_en && !w_pop) begin
            r_count <= r_count + (AW + 1)'(1);
         end else if (!w_wr_en && w_pop) begin
            r_count <= r_count - (AW + 1)'(1);
         end
         if (w_push && !w_wr_en) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign sym       = w_empty ? 2'b00 : r_mem[r_rd_ptr];
   assign sym_valid = !w_empty;
   assign overflow  = r_overflow;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_morse_symbol_sequencer.sv
// Randomised and directed bench for morse_symbol_sequencer; a duration-based
// reference model fills a scoreboard that a negedge monitor drains.
module tb_morse_symbol_sequencer;

   localparam int UNIT  = 66;
   localparam int DEPTH = 4;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic       signal    = 1'b0;
   logic       sym_ready = 1'b1;
   logic [1:0] sym;
   logic       sym_valid;
   logic       overflow;
   logic       busy;

   int         n_checks = 0;
   int         n_fail   = 0;

   logic [1:0] sb_q [$];
   logic [1:0] mon_exp;
   bit         exp_overflow = 1'b0;

   // reference model: current level, its run length, gap bookkeeping
   bit         m_level   = 1'b0;
   int         m_run     = 0;
   bit         m_pending = 1'b0;
   bit         m_letter  = 1'b0;

   int         t4_times [$];

   morse_symbol_sequencer #(
      .UNIT_CYCLES(UNIT),
      .CNT_W      (16),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .signal   (signal),
      .sym      (sym),
      .sym_valid(sym_valid),
      .sym_ready(sym_ready),
      .overflow (overflow),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: every negedge with valid && ready is exactly one pop at the next edge.
   always @(negedge clk) begin
      if (!reset) begin
         if (sym_valid && sym_ready) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_sym: got sym %0d, required no symbol (t=%0t)", sym, $time);
            end else begin
               mon_exp = sb_q.pop_front();
               check("sym_order", int'(sym), int'(mon_exp));
            end
         end
         if (!sym_valid) check("sym_empty_zero", int'(sym), 0);
      end
   end

   task automatic sb_push(input logic [1:0] s, input bit pulse);
      if (!pulse && !sym_ready && sb_q.size() >= DEPTH) exp_overflow = 1'b1;
      else sb_q.push_back(s);
   endtask

   // Hold 'signal' at level l for n sampled clocks; model events computed up front.
   // Entered and left just after a rising edge.
   task automatic seg(input bit l, input int n, input bit pulse);
      int u;
      if (l != m_level) begin
         if (m_level) begin
            u = m_run / UNIT;
            if (u >= 3) begin
               sb_push(2'b01, pulse);
               m_pending = 1'b1;
            end else if (u >= 1) begin
               sb_push(2'b00, pulse);
               m_pending = 1'b1;
            end
            m_letter = 1'b0;
         end
         m_run   = 0;
         m_level = l;
      end
      if (!l) begin
         if (m_pending && m_run < 3*UNIT + 1 && m_run + n >= 3*UNIT + 1) begin
            sb_push(2'b10, 1'b0);
            m_pending = 1'b0;
            m_letter  = 1'b1;
         end
         if (m_letter && m_run < 7*UNIT + 1 && m_run + n >= 7*UNIT + 1) begin
            sb_push(2'b11, 1'b0);
            m_letter = 1'b0;
         end
      end
      m_run += n;
      signal = l;
      if (pulse) begin
         sym_ready = 1'b1;
         @(posedge clk);
         #1 sym_ready = 1'b0;
         repeat (n - 1) @(posedge clk);
      end else begin
         repeat (n) @(posedge clk);
      end
      #1;
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 40) begin
         seg(m_level, 1, 1'b0);
         k++;
      end
      repeat (3) seg(m_level, 1, 1'b0);
      check(name, sb_q.size(), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_sym", int'(sym), 0);
      check("rst_sym_valid", int'(sym_valid), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_busy", int'(busy), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      sb_q.delete();
      exp_overflow = 1'b0;
      m_level   = 1'b0;
      m_run     = 0;
      m_pending = 1'b0;
      m_letter  = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      int bnd [15] = '{1, 65, 66, 67, 131, 132, 133, 197, 198, 199, 200, 461, 462, 463, 464};
      int len;
      repeat (3) @(posedge clk);
      #1;
      do_reset();

      // single dit, valid for exactly one cycle after the fall
      seg(1'b1, 66, 1'b0);
      fork
         seg(1'b0, 100, 1'b0);
         begin
            @(negedge clk) check("t1_valid_before", int'(sym_valid), 0);
            @(negedge clk) check("t1_valid_push", int'(sym_valid), 1);
            @(negedge clk) check("t1_valid_after", int'(sym_valid), 0);
         end
      join
      wait_drain("t1_drain");

      // dah then dit
      do_reset();
      seg(1'b1, 198, 1'b0);
      seg(1'b0, 100, 1'b0);
      seg(1'b1, 132, 1'b0);
      seg(1'b0, 100, 1'b0);
      wait_drain("t2_drain");

      // glitch from idle: nothing pushed, back to idle
      do_reset();
      seg(1'b1, 30, 1'b0);
      seg(1'b0, 600, 1'b0);
      wait_drain("t3_drain");
      check("t3_busy", int'(busy), 0);

      // dit followed by long space: DIT, LETTER, WORD with exact timing
      do_reset();
      seg(1'b1, 66, 1'b0);
      check("t4_busy_mark", int'(busy), 1);
      t4_times.delete();
      fork
         seg(1'b0, 600, 1'b0);
         for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (sym_valid) t4_times.push_back(c);
         end
      join
      wait_drain("t4_drain");
      check("t4_event_count", t4_times.size(), 3);
      if (t4_times.size() == 3) begin
         check("t4_dit_time", t4_times[0], 1);
         check("t4_letter_time", t4_times[1], 199);
         check("t4_word_time", t4_times[2], 463);
      end
      check("t4_busy_end", int'(busy), 0);

      // five dits into a stalled FIFO: one dropped, overflow sticky
      do_reset();
      sym_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seg(1'b1, 66, 1'b0);
         seg(1'b0, 66, 1'b0);
      end
      check("t5_overflow", int'(overflow), 1);
      check("t5_model_overflow", int'(overflow), int'(exp_overflow));
      check("t5_valid_stalled", int'(sym_valid), 1);
      sym_ready = 1'b1;
      seg(1'b0, 66, 1'b0);
      wait_drain("t5_drain");
      check("t5_overflow_held", int'(overflow), 1);

      // full FIFO, pop coincident with DAH push: no overflow
      do_reset();
      sym_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         seg(1'b1, 66, 1'b0);
         seg(1'b0, 66, 1'b0);
      end
      seg(1'b1, 198, 1'b0);
      seg(1'b0, 66, 1'b1);
      check("t6_overflow", int'(overflow), 0);
      sym_ready = 1'b1;
      seg(1'b0, 66, 1'b0);
      wait_drain("t6_drain");
      check("t6_overflow_end", int'(overflow), 0);

      // reset in the middle of a mark: partial element discarded
      do_reset();
      seg(1'b1, 150, 1'b0);
      do_reset();
      seg(1'b1, 10, 1'b0);
      seg(1'b0, 600, 1'b0);
      wait_drain("t7_drain");
      check("t7_busy", int'(busy), 0);

      // randomised marks and spaces around the unit boundaries
      do_reset();
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 1) == 1) len = bnd[$urandom_range(0, 14)];
         else len = $urandom_range(1, 520);
         seg((i % 2) == 0, len, 1'b0);
      end
      seg(1'b0, 500, 1'b0);
      wait_drain("rand_drain");
      check("rand_overflow", int'(overflow), int'(exp_overflow));
      check("rand_busy", int'(busy), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
